// File: rtl/stream_demux_1ton.sv
// rtl/stream_demux_1ton.sv - registered 1-to-N packet demultiplexer with addressed and round-robin steering
module stream_demux_1ton #(
  parameter int DW    = 8,
  parameter int N_CH  = 8,
  parameter int SEL_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic              in_last,
  output logic [N_CH-1:0]   out_valid,
  input  logic [N_CH-1:0]   out_ready,
  output logic [DW-1:0]     out_data,
  output logic              out_last,
  output logic [7:0]        drop_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  // One extra bit so N_CH == 2**SEL_W still compares correctly.
  localparam logic [SEL_W:0]   LP_NCH    = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] LP_RR_MAX = SEL_W'(N_CH - 1);

  state_t             r_state;
  state_t             w_next_state;

  // Output slot
  logic               r_vld;
  logic [SEL_W-1:0]   r_ch;
  logic [DW-1:0]      r_data;
  logic               r_last;

  // Packet context held from first to last beat
  logic [SEL_W-1:0]   r_lock;
  logic               r_lock_mode;
  logic [SEL_W-1:0]   r_rr;
  logic [7:0]         r_drop;

  logic [N_CH-1:0]    w_slot_sel;
  logic               w_slot_free;
  logic               w_in_ready;
  logic               w_acc;
  logic               w_oor;
  logic               w_route;
  logic [SEL_W-1:0]   w_route_ch;
  logic               w_lock_load;
  logic               w_drop_pkt;
  logic               w_rr_adv;

  // The slot frees when empty or when its owning channel takes the beat this cycle.
  assign w_slot_sel  = {{(N_CH-1){1'b0}}, 1'b1} << r_ch;
  assign w_slot_free = ~r_vld | (|(out_ready & w_slot_sel));
  assign w_in_ready  = (r_state == ST_DROP) | w_slot_free;
  assign w_acc       = in_valid & w_in_ready;
  assign w_oor       = ~mode & ({1'b0, sel} >= LP_NCH);

  assign in_ready  = w_in_ready;
  assign out_valid = r_vld ? w_slot_sel : '0;
  assign out_data  = r_data;
  assign out_last  = r_last;
  assign drop_cnt  = r_drop;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: packet boundaries are decided on the first accepted beat only
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_acc && !in_last) begin
          w_next_state = w_oor ? ST_DROP : ST_PASS;
        end
      end
      ST_PASS, ST_DROP: begin
        if (w_acc && in_last) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs: routing decision, lock load, drop and pointer-advance strobes
  always_comb begin
    w_route     = 1'b0;
    w_route_ch  = r_lock;
    w_lock_load = 1'b0;
    w_drop_pkt  = 1'b0;
    w_rr_adv    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_route_ch = mode ? r_rr : sel;
        if (w_acc) begin
          if (w_oor) begin
            w_drop_pkt = 1'b1;
          end else begin
            w_route     = 1'b1;
            w_lock_load = 1'b1;
            w_rr_adv    = mode & in_last;
          end
        end
      end
      ST_PASS: begin
        if (w_acc) begin
          w_route  = 1'b1;
          w_rr_adv = r_lock_mode & in_last;
        end
      end
      default: ;
    endcase
  end

  // Output slot: reload on a routed beat, otherwise empty once drained
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_ch   <= '0;
      r_data <= '0;
      r_last <= 1'b0;
    end else if (w_route) begin
      r_vld  <= 1'b1;
      r_ch   <= w_route_ch;
      r_data <= in_data;
      r_last <= in_last;
    end else if (w_slot_free) begin
      r_vld  <= 1'b0;
    end
  end

  // Packet lock: channel and steering mode captured at packet start
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock      <= '0;
      r_lock_mode <= 1'b0;
    end else if (w_lock_load) begin
      r_lock      <= w_route_ch;
      r_lock_mode <= mode;
    end
  end

  // Round-robin pointer: moves on to the next channel after each delivered round-robin packet
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr <= '0;
    end else if (w_rr_adv) begin
      r_rr <= (r_rr == LP_RR_MAX) ? '0 : r_rr + 1'b1;
    end
  end

  // Drop counter: one count per discarded packet, sticks at 255
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop <= '0;
    end else if (w_drop_pkt && (r_drop != 8'hFF)) begin
      r_drop <= r_drop + 8'd1;
    end
  end

endmodule

// File: doc/stream_demux_1ton.md
Name: stream_demux_1toN

Overview:
Parametrised, registered 1-to-N stream demultiplexer with a valid/ready handshake on every interface. Each packet is steered to one of N_CH output channels, chosen either by the select input (addressed mode) or by a rotating pointer (round-robin mode). The channel is latched on the first beat of a packet and held until its last beat, so packets are never split across channels. It sits between a single upstream producer and N downstream consumers, generalising the fixed 1x8 combinational demux.

Parameters:
DW, 8, data width in bits
N_CH, 8, number of output channels (2..16)
SEL_W, 3, select width; 2**SEL_W >= N_CH

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
mode  input  1  0 = addressed (use sel), 1 = round-robin; sampled only at packet start
sel  input  SEL_W  target channel; sampled with first beat of packet
in_valid  input  1  upstream beat valid
in_ready  output  1  block can accept beat this cycle
in_data  input  DW  beat payload
in_last  input  1  final beat of packet
out_valid  output  N_CH  one-hot per-channel valid; at most one bit set
out_ready  input  N_CH  per-channel downstream ready
out_data  output  DW  payload, shared by all channels
out_last  output  1  last flag, shared by all channels
drop_cnt  output  8  saturating count of dropped packets

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_last=0, drop_cnt=0.
  - FSM goes to IDLE; round-robin pointer rr=0.
  - Any in-flight packet is abandoned; no partial beat survives.
- Handshake: a beat transfers when in_valid & in_ready. A channel transfer completes when out_valid[k] & out_ready[k].
- Output stage: one register slot (vld_r, ch_r, data_r, last_r).
  - in_ready = ~vld_r | out_ready[ch_r], giving full throughput of 1 beat/clk.
  - Latency is 1 clk from input acceptance to out_valid.
  - out_valid = vld_r ? (1 << ch_r) : 0.
- Input data must stay stable while in_valid & ~in_ready. The block does not check this.
- FSM, states IDLE, PASS, DROP:
  - IDLE, on an accepted beat, the target channel t is:
    - mode=0: t = sel
    - mode=1: t = rr
  - IDLE, if mode=0 and sel >= N_CH: enter DROP (or stay in IDLE if in_last). The beat is accepted and discarded. drop_cnt increments once per packet and saturates at 255.
  - IDLE, otherwise: latch ch_lock = t. Go to PASS unless in_last, in which case stay in IDLE.
  - PASS: every accepted beat is routed to ch_lock. sel and mode are ignored. On an accepted in_last beat, go to IDLE.
  - DROP: in_ready=1 irrespective of the output stage. Beats are discarded. On an accepted in_last beat, go to IDLE.
- Round-robin pointer: rr advances on an accepted in_last beat in mode 1, wrapping N_CH-1 -> 0. rr does not advance in mode 0 or on dropped packets.
- Single-beat packet (first beat has in_last=1): valid in every mode. The FSM stays in IDLE.
- Back-pressure: a stalled channel stalls the whole input, because the output slot is shared. Other channels receive nothing meanwhile. This is intentional, to preserve ordering.
- Simultaneous slot drain and new beat in the same cycle: the slot reloads with no bubble.
- rst asserted mid-packet: the next beat after reset is treated as a packet start.
- Non-power-of-two N_CH: codes N_CH..2**SEL_W-1 are out-of-range and are dropped.

Test Plan:
1. Reset, then mode=0, sel=5, 3-beat packet A1,A2,A3 (last on A3), out_ready=all 1s -> out_valid=8'b0010_0000 on three consecutive cycles, each 1 clk after acceptance; out_data=A1,A2,A3; out_last only with A3.
2. Mode=0, sel=2 on first beat, sel changed to 6 mid-packet -> all beats still go to channel 2; next packet with sel=6 goes to channel 6.
3. Mode=1, four single-beat packets, N_CH=8 -> channels 0,1,2,3 in order; reset -> next packet goes to channel 0.
4. Channel 3 holds out_ready[3]=0 for 4 cycles during a 2-beat packet -> out_valid[3] and out_data held stable; in_ready=0 while the slot is full; beats delivered once ready rises; no loss or duplication.
5. N_CH=6, SEL_W=3, mode=0, sel=7, 3-beat packet -> in_ready=1 throughout, out_valid=0, drop_cnt 0->1; following packet with sel=1 is delivered normally.
6. Assert rst during beat 2 of a 4-beat packet -> outputs clear next clk; the subsequent beat with sel=4 is treated as a new packet and routed to channel 4. Continuous back-to-back traffic -> 1 beat/clk with no bubbles.
